// File: rtl/text_msg_loader.sv
// Fills the 16x16 character buffer: loads one ROM message into a row (space-padded after a 0) or blanks it all.
// Latency: load busy MSG_LEN+2 cycles, clear 256; no backpressure, commands arriving while busy are dropped.
module text_msg_loader #(
  parameter int          MSG_LEN    = 16,
  parameter int          N_MSGS     = 8,
  parameter logic [7:0]  SPACE_CODE = 8'h20,
  localparam int         IW         = $clog2(N_MSGS),
  localparam int         AW         = $clog2(N_MSGS * MSG_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          clr,
  input  logic [IW-1:0] msg_id,
  input  logic [3:0]    row,
  output logic [AW-1:0] msg_addr,
  input  logic [7:0]    msg_data,
  output logic          wr_en,
  output logic [7:0]    wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, FIN} state_t;

  localparam logic [3:0] LAST_COL = 4'(MSG_LEN - 1);

  state_t     state;
  logic [3:0] row_q;
  logic [3:0] rc;
  logic [3:0] wc;
  logic       rd_on;
  logic       rd_vld;
  logic       term;
  logic [7:0] load_char;

  // The terminating zero itself is written as a space, as is everything after it.
  always_comb begin
    load_char = msg_data;
    if (term || msg_data == 8'h00) load_char = SPACE_CODE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_q    <= '0;
      rc       <= '0;
      wc       <= '0;
      rd_on    <= 1'b0;
      rd_vld   <= 1'b0;
      term     <= 1'b0;
      msg_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            wr_en   <= 1'b1;
            wr_addr <= 8'd0;
            wr_data <= SPACE_CODE;
          end else if (req) begin
            state    <= LOAD;
            busy     <= 1'b1;
            row_q    <= row;
            term     <= 1'b0;
            rc       <= 4'd0;
            rd_on    <= 1'b1;
            rd_vld   <= 1'b0;
            msg_addr <= AW'(msg_id) * AW'(MSG_LEN);
          end
        end
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= wr_addr + 8'd1;
          if (wr_addr == 8'd254) state <= FIN;
        end
        LOAD: begin
          // ROM data lags the address by one cycle, so the write column trails rc.
          rd_vld <= rd_on;
          wc     <= rc;
          if (rd_on) begin
            if (rc == LAST_COL) begin
              rd_on <= 1'b0;
            end else begin
              rc       <= rc + 4'd1;
              msg_addr <= msg_addr + AW'(1);
            end
          end
          if (rd_vld) begin
            wr_en   <= 1'b1;
            wr_addr <= {row_q, wc};
            wr_data <= load_char;
            if (msg_data == 8'h00) term <= 1'b1;
            if (wc == LAST_COL) state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_msg_loader.sv
// Directed bench for text_msg_loader: registered ROM model, per-cycle output log, hand-written expectations.
module tb_text_msg_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] msg_id = 3'd0;
  logic [3:0] row = 4'd0;
  logic [6:0] msg_addr;
  logic [7:0] msg_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

  text_msg_loader dut (
    .clk(clk), .rst(rst), .req(req), .clr(clr), .msg_id(msg_id), .row(row),
    .msg_addr(msg_addr), .msg_data(msg_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:127];
  always @(posedge clk) msg_data <= rom[msg_addr];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [6:0] m_addr [0:4095];
  logic       m_wen  [0:4095];
  logic [7:0] m_wa   [0:4095];
  logic [7:0] m_wd   [0:4095];
  logic       m_busy [0:4095];
  logic       m_done [0:4095];

  always @(negedge clk) begin
    if (cyc < 4096) begin
      m_addr[cyc] = msg_addr;
      m_wen[cyc]  = wr_en;
      m_wa[cyc]   = wr_addr;
      m_wd[cyc]   = wr_data;
      m_busy[cyc] = busy;
      m_done[cyc] = done;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_msg(input int id, input string s);
    for (int i = 0; i < 16; i++) rom[id*16 + i] = s[i];
  endtask

  task automatic start(input bit now, input bit c, input bit r, input int id, input int rw, output int t);
    if (!now) @(negedge clk);
    clr    = c;
    req    = r;
    msg_id = id[2:0];
    row    = rw[3:0];
    t      = cyc;
    @(negedge clk);
    clr = 1'b0;
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  function automatic int count_wr(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (m_wen[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_busy(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (m_busy[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic check_load(input string tag, input int t, input int base, input int rw, input string s);
    for (int c = 0; c < 16; c++) begin
      chk({tag, "_msg_addr"}, 32'(m_addr[t+1+c]), base + c);
      chk({tag, "_wr_en"},    32'(m_wen[t+3+c]), 1);
      chk({tag, "_wr_addr"},  32'(m_wa[t+3+c]), rw*16 + c);
      chk({tag, "_wr_data"},  32'(m_wd[t+3+c]), 32'(s[c]));
    end
    chk({tag, "_no_early_wr"}, 32'(m_wen[t+2]), 0);
    chk({tag, "_no_late_wr"},  32'(m_wen[t+19]), 0);
    chk({tag, "_done_early"},  32'(m_done[t+18]), 0);
    chk({tag, "_done"},        32'(m_done[t+19]), 1);
    chk({tag, "_busy_len"},    count_busy(t, t+19), 18);
  endtask

  int t, t2, ok;

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h2E;
    put_msg(0, "GAMEqXYZWVUTSRQP");
    rom[4] = 8'h00;
    put_msg(1, "ABCDEFGHIJKLMNOP");
    put_msg(2, "HELLO WORLD 1234");

    repeat (3) @(negedge clk);
    chk("rst_wr_en",    32'(wr_en), 0);
    chk("rst_wr_addr",  32'(wr_addr), 0);
    chk("rst_wr_data",  32'(wr_data), 0);
    chk("rst_msg_addr", 32'(msg_addr), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_done",     32'(done), 0);
    rst = 1'b0;

    start(0, 0, 1, 2, 5, t);
    wait_done(40);
    @(negedge clk);
    check_load("basic", t, 32, 5, "HELLO WORLD 1234");

    start(0, 0, 1, 0, 0, t);
    wait_done(40);
    @(negedge clk);
    check_load("term", t, 0, 0, "GAME            ");

    start(0, 1, 0, 0, 0, t);
    wait_done(300);
    @(negedge clk);
    ok = 0;
    for (int i = 0; i < 256; i++)
      if (m_wen[t+1+i] === 1'b1 && m_wa[t+1+i] === 8'(i) && m_wd[t+1+i] === 8'h20) ok++;
    chk("clr_writes",     ok, 256);
    chk("clr_wr_after",   32'(m_wen[t+257]), 0);
    chk("clr_done_early", 32'(m_done[t+256]), 0);
    chk("clr_done",       32'(m_done[t+257]), 1);
    chk("clr_busy_len",   count_busy(t, t+257), 256);

    start(0, 1, 1, 1, 3, t);
    wait_done(300);
    @(negedge clk);
    chk("prio_first_addr", 32'(m_wa[t+1]), 0);
    chk("prio_first_data", 32'(m_wd[t+1]), 32'h20);
    chk("prio_writes",     count_wr(t, t+257), 256);
    chk("prio_done",       32'(m_done[t+257]), 1);

    start(0, 0, 1, 2, 7, t);
    while (cyc < t + 5) @(negedge clk);
    req = 1'b1; msg_id = 3'd0; row = 4'd9;
    @(negedge clk);
    req = 1'b0; msg_id = 3'd5; row = 4'd12;
    wait_done(40);
    repeat (6) @(negedge clk);
    check_load("rej", t, 32, 7, "HELLO WORLD 1234");
    chk("rej_count",   count_wr(t, t+25), 16);
    chk("rej_no_busy", count_busy(t+19, t+25), 0);

    start(0, 0, 1, 2, 4, t);
    while (cyc < t + 8) @(negedge clk);
    chk("rstmid_writing", 32'(wr_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wr_en", 32'(wr_en), 0);
    chk("rstmid_busy",  32'(busy), 0);
    chk("rstmid_done",  32'(done), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("rstmid_no_done",  count_wr(t+9, t+33), 0);
    ok = 0;
    for (int i = t + 9; i <= t + 33; i++) if (m_done[i] === 1'b1) ok++;
    chk("rstmid_no_done_pulse", ok, 0);
    start(0, 0, 1, 2, 6, t);
    wait_done(40);
    @(negedge clk);
    check_load("post_rst", t, 32, 6, "HELLO WORLD 1234");

    start(0, 0, 1, 0, 1, t);
    wait_done(40);
    start(1, 0, 1, 1, 2, t2);
    wait_done(40);
    @(negedge clk);
    chk("b2b_gap", t2 - t, 19);
    check_load("b2b1", t, 0, 1, "GAME            ");
    check_load("b2b2", t2, 16, 2, "ABCDEFGHIJKLMNOP");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
